// File: rtl/pipe_arb_pkg.sv
// Shared types and helpers for the PIPE request arbiter.
package pipe_arb_pkg;

  localparam int OPND_W    = 6;
  localparam int MODE_W    = 2;
  localparam int OUT_W     = 27;

  // Tags are sized for the largest supported requester count so that the
  // package does not depend on the arbiter's N_REQ parameter.
  localparam int N_REQ_MAX = 8;
  localparam int TAG_W     = $clog2(N_REQ_MAX);

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic [OPND_W-1:0] in1;
    logic [OPND_W-1:0] in2;
    logic [OPND_W-1:0] in3;
    logic [OPND_W-1:0] in4;
    logic [MODE_W-1:0] mode;
  } pipe_req_t;

  // First valid requester at or above ptr, wrapping at n. Returns 0 when
  // nothing is valid; callers qualify the result with |valid.
  function automatic tag_t rr_next(input logic [N_REQ_MAX-1:0] valid,
                                   input tag_t ptr, input int n);
    tag_t g;
    logic found;
    int   idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ_MAX; k++) begin
      idx = (int'(ptr) + k) % n;
      if ((k < n) && !found && valid[idx[TAG_W-1:0]]) begin
        g     = tag_t'(idx);
        found = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/pipe_tag_fifo.sv
// In-order FIFO of requester tags, one entry per outstanding PIPE operation.
module pipe_tag_fifo
  import pipe_arb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  tag_t                       din,
  output tag_t                       head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  tag_t             mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  // Tag storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Pointers wrap naturally; count tracks occupancy including the full state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pipe_arbiter.sv
// Round-robin sharing of one PIPE datapath among N_REQ requesters, with
// in-order tag tracking so each result returns to its issuer.
module pipe_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*OPND_W-1:0]   req_in1,
  input  logic [N_REQ*OPND_W-1:0]   req_in2,
  input  logic [N_REQ*OPND_W-1:0]   req_in3,
  input  logic [N_REQ*OPND_W-1:0]   req_in4,
  input  logic [N_REQ*MODE_W-1:0]   req_mode,
  output logic                      pipe_in_valid,
  output logic [OPND_W-1:0]         pipe_in_1,
  output logic [OPND_W-1:0]         pipe_in_2,
  output logic [OPND_W-1:0]         pipe_in_3,
  output logic [OPND_W-1:0]         pipe_in_4,
  output logic [MODE_W-1:0]         pipe_mode,
  input  logic                      pipe_out_valid,
  input  logic [OUT_W-1:0]          pipe_out_value,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [OUT_W-1:0]          rsp_value,
  output logic                      err_unexpected
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  tag_t              rr_ptr;
  tag_t              grant;
  tag_t              rr_inc;
  tag_t              head;
  logic [N_REQ-1:0]  grant_oh;
  logic [N_REQ-1:0]  head_oh;
  logic              any_valid;
  logic              can_issue;
  logic              xfer;
  logic              pop;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  pipe_req_t         reqs [N_REQ];
  pipe_req_t         sel_req;

  // Unflatten the requester buses into one record per requester.
  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign reqs[i] = {req_in1[OPND_W*i +: OPND_W], req_in2[OPND_W*i +: OPND_W],
                      req_in3[OPND_W*i +: OPND_W], req_in4[OPND_W*i +: OPND_W],
                      req_mode[MODE_W*i +: MODE_W]};
  end

  // Issue decision depends only on registered occupancy, so a result
  // arriving this cycle cannot open a slot until the next one.
  assign any_valid = |req_valid;
  assign can_issue = (count < CNT_W'(MAX_INFLIGHT)) && !rst;
  assign grant     = rr_next(N_REQ_MAX'(req_valid), rr_ptr, N_REQ);
  assign grant_oh  = ONE << grant;
  assign req_ready = grant_oh & {N_REQ{can_issue && any_valid}};
  assign xfer      = can_issue && any_valid;
  assign sel_req   = reqs[grant[IDX_W-1:0]];
  assign rr_inc    = (int'(grant) == N_REQ - 1) ? '0 : grant + 1'b1;

  assign pop       = pipe_out_valid && !empty;
  assign head_oh   = ONE << head;

  pipe_tag_fifo #(
    .DEPTH (MAX_INFLIGHT)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (xfer),
    .pop   (pop),
    .din   (grant),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Issue stage: register the granted payload toward PIPE, advance priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_in_valid <= 1'b0;
      pipe_in_1     <= '0;
      pipe_in_2     <= '0;
      pipe_in_3     <= '0;
      pipe_in_4     <= '0;
      pipe_mode     <= '0;
      rr_ptr        <= '0;
    end else if (xfer) begin
      pipe_in_valid <= 1'b1;
      pipe_in_1     <= sel_req.in1;
      pipe_in_2     <= sel_req.in2;
      pipe_in_3     <= sel_req.in3;
      pipe_in_4     <= sel_req.in4;
      pipe_mode     <= sel_req.mode;
      rr_ptr        <= rr_inc;
    end else begin
      pipe_in_valid <= 1'b0;
      pipe_in_1     <= '0;
      pipe_in_2     <= '0;
      pipe_in_3     <= '0;
      pipe_in_4     <= '0;
      pipe_mode     <= '0;
    end
  end

  // Response stage: route each result to the head tag; flag untracked results.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid      <= '0;
      rsp_value      <= '0;
      err_unexpected <= 1'b0;
    end else begin
      if (pop) begin
        rsp_valid <= head_oh;
        rsp_value <= pipe_out_value;
      end else begin
        rsp_valid <= '0;
      end
      if (pipe_out_valid && empty) err_unexpected <= 1'b1;
    end
  end

  // full is implied by count; kept on the FIFO interface for other users.
  logic unused_full;
  assign unused_full = full;

endmodule
